// File: rtl/ex_flag_stage.sv
// EX/MEM boundary stage: registers the ALU result and write-back info, keeps the
// Z/V/N flag register, resolves branches and holds a sticky halt state.
module ex_flag_stage #(
    parameter int WIDTH = 16,
    parameter int REG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_ovfl,
    input  logic [2:0]       cond,
    input  logic [REG_W-1:0] dst_reg,
    input  logic             reg_wen,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_result,
    output logic [REG_W-1:0] out_dst,
    output logic             out_wen,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n,
    output logic             br_taken,
    output logic             halted
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Branch condition evaluated against the flags settled by earlier instructions.
    function automatic logic cond_met(input logic [2:0] cc, input logic z,
                                      input logic v, input logic n);
        logic met;
        case (cc)
            3'b000:  met = ~z;
            3'b001:  met = z;
            3'b010:  met = ~z & ~n;
            3'b011:  met = n;
            3'b100:  met = z | ~n;
            3'b101:  met = z | n;
            3'b110:  met = v;
            default: met = 1'b1;
        endcase
        return met;
    endfunction

    logic [0:0]       state_q, state_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [REG_W-1:0] dst_q, dst_d;
    logic             wen_q, wen_d;
    logic             z_q, z_d;
    logic             v_q, v_d;
    logic             n_q, n_d;
    logic             br_q, br_d;
    logic             accept;
    logic             zero;

    assign accept = in_valid & ~stall & ~flush & (state_q == ST_RUN);
    assign zero   = (alu_result == '0);

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        result_d = result_q;
        dst_d    = dst_q;
        wen_d    = wen_q;
        z_d      = z_q;
        v_d      = v_q;
        n_d      = n_q;
        br_d     = br_q;

        // A bubble (flush, idle or halted) clears the live-instruction bits; a pure stall holds.
        if (flush || !stall) begin
            valid_d = 1'b0;
            wen_d   = 1'b0;
            br_d    = 1'b0;
        end

        if (accept) begin
            valid_d  = 1'b1;
            result_d = alu_result;
            dst_d    = dst_reg;
            wen_d    = reg_wen & (opcode != OP_HLT);
            br_d     = ((opcode == OP_B) || (opcode == OP_BR)) & cond_met(cond, z_q, v_q, n_q);
            case (opcode)
                OP_ADD, OP_SUB: begin
                    z_d = zero;
                    v_d = alu_ovfl;
                    n_d = alu_result[WIDTH-1];
                end
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: z_d = zero;
                default: ;
            endcase
            if (opcode == OP_HLT) begin
                state_d = ST_HALTED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            valid_q  <= 1'b0;
            result_q <= '0;
            dst_q    <= '0;
            wen_q    <= 1'b0;
            z_q      <= 1'b0;
            v_q      <= 1'b0;
            n_q      <= 1'b0;
            br_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            dst_q    <= dst_d;
            wen_q    <= wen_d;
            z_q      <= z_d;
            v_q      <= v_d;
            n_q      <= n_d;
            br_q     <= br_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_dst    = dst_q;
    assign out_wen    = wen_q & valid_q;
    assign flag_z     = z_q;
    assign flag_v     = v_q;
    assign flag_n     = n_q;
    assign br_taken   = br_q;
    assign halted     = (state_q == ST_HALTED);

endmodule

// File: tb/tb_ex_flag_stage.sv
// Bench for ex_flag_stage: directed scenarios then randomized traffic against a
// cycle-level behavioural model of the stage.
module tb_ex_flag_stage;

    localparam int WIDTH = 16;
    localparam int REG_W = 4;

    logic             clk = 1'b0;
    logic             rst, stall, flush, in_valid, alu_ovfl, reg_wen;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] alu_result;
    logic [2:0]       cond;
    logic [REG_W-1:0] dst_reg;
    logic             out_valid, out_wen, flag_z, flag_v, flag_n, br_taken, halted;
    logic [WIDTH-1:0] out_result;
    logic [REG_W-1:0] out_dst;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic             m_valid, m_wen, m_z, m_v, m_n, m_br, m_halted;
    logic [WIDTH-1:0] m_result;
    logic [REG_W-1:0] m_dst;

    ex_flag_stage #(.WIDTH(WIDTH), .REG_W(REG_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .opcode(opcode), .alu_result(alu_result), .alu_ovfl(alu_ovfl), .cond(cond),
        .dst_reg(dst_reg), .reg_wen(reg_wen), .out_valid(out_valid),
        .out_result(out_result), .out_dst(out_dst), .out_wen(out_wen),
        .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n), .br_taken(br_taken),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: what the stage must hold after one edge with the current inputs.
    task automatic model_edge();
        logic taken;
        if (rst) begin
            m_valid = 0; m_wen = 0; m_br = 0; m_z = 0; m_v = 0; m_n = 0;
            m_halted = 0; m_result = 0; m_dst = 0;
        end else if (flush) begin
            m_valid = 0; m_wen = 0; m_br = 0;
        end else if (stall) begin
            // everything holds
        end else if (!in_valid || m_halted) begin
            m_valid = 0; m_wen = 0; m_br = 0;
        end else begin
            case (cond)
                3'd0: taken = !m_z;
                3'd1: taken = m_z;
                3'd2: taken = !m_z && !m_n;
                3'd3: taken = m_n;
                3'd4: taken = m_z || !m_n;
                3'd5: taken = m_z || m_n;
                3'd6: taken = m_v;
                default: taken = 1;
            endcase
            m_br     = (opcode == 4'd12 || opcode == 4'd13) ? taken : 1'b0;
            m_valid  = 1;
            m_result = alu_result;
            m_dst    = dst_reg;
            m_wen    = reg_wen && opcode != 4'd15;
            if (opcode <= 4'd1) begin
                m_z = (alu_result == 0);
                m_v = alu_ovfl;
                m_n = alu_result[WIDTH-1];
            end else if (opcode == 4'd2 || (opcode >= 4'd4 && opcode <= 4'd6)) begin
                m_z = (alu_result == 0);
            end
            if (opcode == 4'd15) m_halted = 1;
        end
    endtask

    task automatic compare_all();
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_result", 32'(out_result), 32'(m_result));
        check("out_dst", 32'(out_dst), 32'(m_dst));
        check("out_wen", 32'(out_wen), 32'(m_wen));
        check("flag_z", 32'(flag_z), 32'(m_z));
        check("flag_v", 32'(flag_v), 32'(m_v));
        check("flag_n", 32'(flag_n), 32'(m_n));
        check("br_taken", 32'(br_taken), 32'(m_br));
        check("halted", 32'(halted), 32'(m_halted));
    endtask

    task automatic drive(input logic r, input logic s, input logic f, input logic v,
                         input logic [3:0] op, input logic [WIDTH-1:0] res,
                         input logic ov, input logic [2:0] cc);
        rst = r; stall = s; flush = f; in_valid = v; opcode = op;
        alu_result = res; alu_ovfl = ov; cond = cc;
        dst_reg = 4'(op + 3); reg_wen = 1'b1;
        @(posedge clk);
        #1;
        model_edge();
        compare_all();
    endtask

    initial begin
        m_valid = 0; m_wen = 0; m_br = 0; m_z = 0; m_v = 0; m_n = 0;
        m_halted = 0; m_result = 0; m_dst = 0;
        drive(1, 0, 0, 0, 4'd0, 16'h1234, 0, 0);
        drive(1, 1, 0, 1, 4'd0, 16'h1234, 1, 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_flags", {29'd0, flag_z, flag_v, flag_n}, 0);
        check("rst_halted", 32'(halted), 0);

        // Zero result sets Z
        drive(0, 0, 0, 1, 4'd0, 16'h0000, 0, 0);
        check("t1_znv", {29'd0, flag_z, flag_v, flag_n}, 32'b100);
        check("t1_valid", 32'(out_valid), 1);

        // Saturated extremes
        drive(0, 0, 0, 1, 4'd0, 16'h7FFF, 1, 0);
        check("t2_add_znv", {29'd0, flag_z, flag_v, flag_n}, 32'b010);
        drive(0, 0, 0, 1, 4'd1, 16'h8000, 1, 0);
        check("t2_sub_znv", {29'd0, flag_z, flag_v, flag_n}, 32'b011);

        // XOR only touches Z; LT branch sees N=1
        drive(0, 0, 0, 1, 4'd2, 16'h0000, 0, 0);
        check("t3_xor_znv", {29'd0, flag_z, flag_v, flag_n}, 32'b111);
        drive(0, 0, 0, 1, 4'd12, 16'h0000, 0, 3'b011);
        check("t3_b_lt", 32'(br_taken), 1);

        // Stall for three cycles, then release
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 1, 4'd0, 16'h0005, 0, 0);
            check("t4_hold_br", 32'(br_taken), 1);
            check("t4_hold_z", 32'(flag_z), 1);
        end
        drive(0, 0, 0, 1, 4'd0, 16'h0005, 0, 0);
        check("t4_result", 32'(out_result), 32'h5);
        check("t4_z", 32'(flag_z), 0);

        // Flush, with and without stall
        drive(0, 0, 1, 1, 4'd0, 16'h0000, 0, 0);
        check("t5_valid", 32'(out_valid), 0);
        check("t5_z", 32'(flag_z), 0);
        drive(0, 0, 0, 1, 4'd0, 16'h0007, 0, 0);
        drive(0, 1, 1, 1, 4'd0, 16'h0000, 0, 0);
        check("t5s_valid", 32'(out_valid), 0);
        check("t5s_z", 32'(flag_z), 0);

        // HLT and recovery by reset
        drive(0, 0, 0, 1, 4'd15, 16'h0000, 0, 0);
        check("t6_halted", 32'(halted), 1);
        check("t6_valid", 32'(out_valid), 1);
        check("t6_wen", 32'(out_wen), 0);
        drive(0, 0, 0, 1, 4'd0, 16'h0000, 0, 0);
        check("t6_ignored", 32'(out_valid), 0);
        check("t6_z_frozen", 32'(flag_z), 0);
        drive(1, 0, 0, 0, 4'd0, 16'h0000, 0, 0);
        check("t6_rst_halted", 32'(halted), 0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [WIDTH-1:0] res;
            case ($urandom_range(0, 3))
                0: res = 16'h0000;
                1: res = 16'h7FFF;
                2: res = 16'h8000;
                default: res = 16'($urandom);
            endcase
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 4) != 0,
                  ($urandom_range(0, 40) == 0) ? 4'd15 : 4'($urandom),
                  res, 1'($urandom), 3'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
